car_alarm_ctrl: RTL and testbench
=================================

Name: car_alarm_ctrl

Overview:
Synchronous vehicle-alarm controller that drives the horn output Bocina from an arm switch, a panic button and five intrusion sensors. Those sensors are door, hood, trunk, glovebox and window. Intrusion alarms and panic alarms latch, and the horn has a guaranteed minimum on-time. The block sits between debounced switch inputs and the horn driver, and also reports which sensors caused the alarm.

Parameters:
MIN_ON_CYCLES, 4, minimum number of clock cycles Bocina stays high once asserted; legal range is 1 or greater.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
A  input  1  arm switch; 1 = armed.
P  input  1  door sensor; 1 = open.
Co  input  1  hood sensor.
Ca  input  1  trunk sensor.
G  input  1  glovebox sensor.
V  input  1  window sensor.
Pa  input  1  panic button; 1 = pressed.
Bocina  output  1  horn drive; 1 = sound.
Causa  output  5  sticky record of the sensors that triggered the alarm, in bit order {V,G,Ca,Co,P}.

Behaviour:
- One clock domain. Reset is synchronous and active-high. rst has priority over every other input.
- Reset values: state = DISARMED, Bocina = 0, Causa = 5'b00000, hold counter = 0.
- Trigger condition: trig = A & (P|Co|Ca|G|V). It is evaluated every cycle from the current input values.
- States are DISARMED, ARMED, ALARM and PANIC. The next state is chosen in this priority order:
  1. Pa=1 from any state: go to PANIC and load the hold counter with MIN_ON_CYCLES-1.
  2. In PANIC with Pa=0: stay in PANIC while the counter is nonzero, decrementing it each cycle. When the counter is 0, go to ALARM if trig (loading the counter), else to ARMED if A=1, else to DISARMED.
  3. In DISARMED or ARMED: go to ALARM if trig (loading the counter), else to ARMED if A=1, else to DISARMED. Arming while a sensor is already open goes straight to ALARM.
  4. In ALARM: the alarm is sticky and stays in ALARM while A=1, even after all sensors close. The counter decrements to 0 and then holds. Exit to DISARMED only when A=0 and the counter is 0. If A=0 before MIN_ON_CYCLES cycles have elapsed, the horn continues until they have.
- Bocina is a registered output: 1 when the registered state is ALARM or PANIC, else 0. Latency is exactly one clock from the sampled cause to Bocina=1.
- Causa:
  - On every cycle where the next state is ALARM, Causa <= Causa | {V,G,Ca,Co,P} & {5{A}}.
  - Cleared to 0 when the next state is DISARMED.
  - Unchanged in ARMED and in PANIC.
- Pa held continuously keeps PANIC indefinitely. The counter reloads on every Pa=1 cycle.
- Simultaneous Pa and trig: PANIC wins. The ALARM decision is made when PANIC expires.
- Reset asserted in any state, including mid-hold: the next edge returns all outputs to their reset values.
- There are no arithmetic wrap cases. The counter width is clog2(MIN_ON_CYCLES+1) and it saturates at 0.

Test Plan:
1. Reset behaviour: rst=1 for 2 cycles with all inputs at 0 -> Bocina=0 and Causa=00000. Then rst=0 with A=0 and a sensor toggled -> Bocina stays 0.
2. Panic: Pa=1 for 1 cycle while disarmed -> Bocina=1 from the next edge for exactly 4 cycles (MIN_ON_CYCLES=4), then 0.
3. Walking sensor: A=1, then one-hot sensors 00001, 00010, 00100, 01000, 10000 one cycle each, then 00000 -> Bocina=1 one cycle after the first sensor. Bocina stays 1 after the sensors clear. Causa=11111.
4. Disarm with hold: trigger G only, then drop A on the next cycle -> Bocina stays 1 for 4 cycles total, then 0. Causa=01000, then 00000 once DISARMED.
5. Arming into an open door: P=1, then A=1 -> ALARM with Bocina=1 at the next edge and Causa=00001.
6. Reset mid-alarm: in ALARM with A=1, assert rst for 1 cycle -> Bocina=0 and Causa=0 at that edge. After release with P=0, the next state is ARMED.

Source files
------------

// File: rtl/car_alarm_ctrl.sv
// Vehicle alarm controller: latching intrusion/panic alarms driving the horn
// (Bocina) with a guaranteed minimum on-time, plus a sticky cause record.
module car_alarm_ctrl #(
    parameter int unsigned MIN_ON_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       A,
    input  logic       P,
    input  logic       Co,
    input  logic       Ca,
    input  logic       G,
    input  logic       V,
    input  logic       Pa,
    output logic       Bocina,
    output logic [4:0] Causa
);

    localparam int unsigned CW = $clog2(MIN_ON_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(MIN_ON_CYCLES - 1);

    localparam logic [1:0] S_DISARMED = 2'd0;
    localparam logic [1:0] S_ARMED    = 2'd1;
    localparam logic [1:0] S_ALARM    = 2'd2;
    localparam logic [1:0] S_PANIC    = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    causa_q, causa_d;
    logic          bocina_q, bocina_d;

    logic [4:0] sens;
    logic       trig;
    logic       cnt_zero;

    assign sens     = {V, G, Ca, Co, P};
    assign trig     = A & (|sens);
    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        if (Pa) begin
            state_d = S_PANIC;
            cnt_d   = HOLD_LOAD;
        end else begin
            case (state_q)
                S_PANIC: begin
                    if (!cnt_zero) begin
                        cnt_d = cnt_q - CW'(1);
                    end else if (trig) begin
                        state_d = S_ALARM;
                        cnt_d   = HOLD_LOAD;
                    end else begin
                        state_d = A ? S_ARMED : S_DISARMED;
                    end
                end
                S_ALARM: begin
                    // Counter saturates at zero; exit needs both disarm and an expired hold.
                    if (!cnt_zero) begin
                        cnt_d = cnt_q - CW'(1);
                    end else if (!A) begin
                        state_d = S_DISARMED;
                    end
                end
                default: begin
                    if (trig) begin
                        state_d = S_ALARM;
                        cnt_d   = HOLD_LOAD;
                    end else begin
                        state_d = A ? S_ARMED : S_DISARMED;
                    end
                end
            endcase
        end
    end

    always_comb begin
        causa_d = causa_q;
        if (state_d == S_ALARM) begin
            causa_d = causa_q | (sens & {5{A}});
        end else if (state_d == S_DISARMED) begin
            causa_d = '0;
        end
    end

    assign bocina_d = (state_d == S_ALARM) || (state_d == S_PANIC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_DISARMED;
            cnt_q    <= '0;
            causa_q  <= '0;
            bocina_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            causa_q  <= causa_d;
            bocina_q <= bocina_d;
        end
    end

    assign Bocina = bocina_q;
    assign Causa  = causa_q;

endmodule

// File: tb/tb_car_alarm_ctrl.sv
// Directed bench for car_alarm_ctrl with MIN_ON_CYCLES = 4.
module tb_car_alarm_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       A;
    logic       Pa;
    logic [4:0] sens;      // {V,G,Ca,Co,P}
    logic       Bocina;
    logic [4:0] Causa;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    car_alarm_ctrl #(.MIN_ON_CYCLES(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .A     (A),
        .P     (sens[0]),
        .Co    (sens[1]),
        .Ca    (sens[2]),
        .G     (sens[3]),
        .V     (sens[4]),
        .Pa    (Pa),
        .Bocina(Bocina),
        .Causa (Causa)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic exp);
        check(tag, {4'b0, Bocina}, {4'b0, exp});
    endtask

    initial begin
        rst = 1'b1; A = 1'b0; Pa = 1'b0; sens = 5'b00000;

        // Reset
        tick(); tick();
        chk_b("rst_bocina", 1'b0);
        check("rst_causa", Causa, 5'b00000);
        rst = 1'b0; sens = 5'b00001;
        tick(); chk_b("disarmed_door", 1'b0);
        sens = 5'b00010;
        tick(); chk_b("disarmed_hood", 1'b0);
        check("disarmed_causa", Causa, 5'b00000);
        sens = 5'b00000;

        // Single-cycle panic while disarmed: exactly 4 cycles of horn
        Pa = 1'b1; tick(); Pa = 1'b0;
        chk_b("panic_c1", 1'b1);
        tick(); chk_b("panic_c2", 1'b1);
        tick(); chk_b("panic_c3", 1'b1);
        tick(); chk_b("panic_c4", 1'b1);
        check("panic_causa", Causa, 5'b00000);
        tick(); chk_b("panic_end", 1'b0);

        // Walking sensors while armed
        A = 1'b1; tick(); chk_b("armed_idle", 1'b0);
        sens = 5'b00001; tick();
        chk_b("walk_first", 1'b1);
        check("walk_causa0", Causa, 5'b00001);
        for (int i = 1; i < 5; i++) begin
            sens = 5'b00001 << i;
            tick(); chk_b("walk_hold", 1'b1);
        end
        sens = 5'b00000; tick();
        chk_b("walk_sticky", 1'b1);
        check("walk_causa", Causa, 5'b11111);
        tick(); chk_b("walk_sticky2", 1'b1);
        A = 1'b0; tick();
        chk_b("walk_disarm", 1'b0);
        check("walk_disarm_causa", Causa, 5'b00000);

        // Glovebox trigger, then immediate disarm: minimum on-time honoured
        A = 1'b1; tick();
        sens = 5'b01000; tick();
        chk_b("hold_c1", 1'b1);
        check("hold_causa", Causa, 5'b01000);
        A = 1'b0; sens = 5'b00000;
        tick(); chk_b("hold_c2", 1'b1);
        tick(); chk_b("hold_c3", 1'b1);
        tick(); chk_b("hold_c4", 1'b1);
        check("hold_causa_c4", Causa, 5'b01000);
        tick(); chk_b("hold_end", 1'b0);
        check("hold_end_causa", Causa, 5'b00000);

        // Arming into an open door
        sens = 5'b00001; tick(); chk_b("door_disarmed", 1'b0);
        A = 1'b1; tick();
        chk_b("arm_open_door", 1'b1);
        check("arm_open_causa", Causa, 5'b00001);

        // Reset mid-alarm
        rst = 1'b1; tick();
        chk_b("midrst_bocina", 1'b0);
        check("midrst_causa", Causa, 5'b00000);
        rst = 1'b0; sens = 5'b00000; tick();
        chk_b("postrst_armed", 1'b0);
        check("postrst_causa", Causa, 5'b00000);

        // Simultaneous panic and trigger: panic wins, alarm decided on expiry
        Pa = 1'b1; sens = 5'b00100; tick(); Pa = 1'b0;
        chk_b("pt_c1", 1'b1);
        check("pt_causa_c1", Causa, 5'b00000);
        tick(); tick(); tick();
        chk_b("pt_c4", 1'b1);
        check("pt_causa_c4", Causa, 5'b00000);
        tick();
        chk_b("pt_alarm", 1'b1);
        check("pt_causa_alarm", Causa, 5'b00100);

        // Held panic keeps horn on; hold restarts from the last Pa cycle
        rst = 1'b1; sens = 5'b00000; A = 1'b0; tick(); rst = 1'b0;
        Pa = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(); chk_b("panic_held", 1'b1);
        end
        Pa = 1'b0;
        tick(); chk_b("panic_rel1", 1'b1);
        tick(); chk_b("panic_rel2", 1'b1);
        tick(); chk_b("panic_rel3", 1'b1);
        tick(); chk_b("panic_rel_end", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
